// File: rtl/mux_74157.sv
// mux_74157: WIDTH-bit 2:1 selector with active-low strobe, after the 74LS157.
// Drives a combinational output and a registered copy of it for synchronous consumers.
module mux_74157 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             select,
    input  logic             strobe_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q
);
    logic [WIDTH-1:0] out_d;

    // A ternary on select keeps bits where a and d agree defined even if select is X.
    always_comb out_d = strobe_n ? '0 : (select ? d : a);

    assign out = out_d;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) out_q <= '0;
        else        out_q <= out_d;
endmodule

// File: tb/tb_mux_74157.sv
// tb_mux_74157: directed and random checks of mux_74157 against a bit-level reference.
module tb_mux_74157;
    localparam int W = 4;
    logic         clk = 0, rst_n = 0, select = 0, strobe_n = 0;
    logic [W-1:0] a = '0, d = '0, out, out_q;
    logic [W-1:0] exp_q = '0;
    int           n_chk = 0, n_pass = 0;

    mux_74157 #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .select(select), .strobe_n(strobe_n),
        .a(a), .d(d), .out(out), .out_q(out_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", tag, got, exp);
    endtask

    // Each output bit picks its own source bit; a disabled strobe zeroes everything.
    function automatic logic [W-1:0] ref_mux(input logic sel, input logic sn,
                                             input logic [W-1:0] va, input logic [W-1:0] vd);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = sn ? 1'b0 : (sel ? vd[i] : va[i]);
        return r;
    endfunction

    task automatic apply(input string tag, input logic sel, input logic sn,
                         input logic [W-1:0] va, input logic [W-1:0] vd);
        @(negedge clk);
        select = sel; strobe_n = sn; a = va; d = vd;
        #1;
        check({tag, "_out"}, out, ref_mux(sel, sn, va, vd));
        check({tag, "_hold"}, out_q, exp_q);
        @(posedge clk);
        #1;
        exp_q = ref_mux(sel, sn, va, vd);
        check({tag, "_q"}, out_q, exp_q);
    endtask

    initial begin
        #2;
        check("rst_out", out, 4'b0000);
        check("rst_q", out_q, 4'b0000);
        a = 4'b1111; d = 4'b1111;
        @(posedge clk); #1;
        check("rst_q_edge", out_q, 4'b0000);
        check("rst_out_live", out, 4'b1111);
        a = '0; d = '0;
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        check("idle_q", out_q, 4'b0000);
        check("idle_out", out, 4'b0000);

        apply("togA0", 0, 0, 4'b1010, 4'b0101);
        apply("togA1", 1, 0, 4'b1010, 4'b0101);
        apply("togB0", 0, 0, 4'b1111, 4'b0000);
        apply("togB1", 1, 0, 4'b1111, 4'b0000);
        apply("togC0", 0, 0, 4'b0011, 4'b1100);
        apply("togC1", 1, 0, 4'b0011, 4'b1100);
        apply("strb0", 0, 1, 4'b1111, 4'b1111);
        apply("strb1", 1, 1, 4'b1111, 4'b1111);
        apply("strbon", 1, 0, 4'b1111, 4'b1111);

        apply("pre_rst", 0, 0, 4'b1010, 4'b0110);
        @(negedge clk); #2;
        rst_n = 0;
        #1;
        check("midrst_q", out_q, 4'b0000);
        check("midrst_out", out, 4'b1010);
        @(posedge clk); #1;
        check("midrst_q_edge", out_q, 4'b0000);
        @(negedge clk); rst_n = 1;
        #1;
        check("rel_q_wait", out_q, 4'b0000);
        @(posedge clk); #1;
        check("rel_q", out_q, 4'b1010);
        exp_q = 4'b1010;

        for (int k = 0; k < 200; k++)
            apply("rnd", 1'($urandom), 1'($urandom_range(0, 3) == 0), W'($urandom), W'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mux_74157.md
Name: mux_74157

Overview:
- WIDTH-bit 2:1 data selector modelled on the 74LS157 quad 2-line-to-1-line multiplexer.
- In the SAP-1 datapath it picks the RAM address source: `a` carries the program-counter/MAR path and `d` carries the manual address switches.
- Provides the classic combinational output with an active-low strobe.
- Also provides a registered copy of that output for synchronous consumers.

Parameters:
- WIDTH, 4, bit width of the data inputs and outputs (74157 = 4).

Ports:
- clk  input  1  system clock; only the registered output uses it.
- rst_n  input  1  asynchronous active-low reset.
- select  input  1  source select: 0 picks a, 1 picks d.
- strobe_n  input  1  active-low enable (74157 G pin); 1 forces outputs to zero.
- a  input  WIDTH  data input A, selected when select=0.
- d  input  WIDTH  data input D (74157 "B" side), selected when select=1.
- out  output  WIDTH  combinational selected data.
- out_q  output  WIDTH  out registered on the rising edge of clk.

Behaviour:
- Combinational path:
  - out = 0 when strobe_n=1.
  - Otherwise out = a when select=0, and out = d when select=1.
  - Zero clock latency, evaluated continuously.
  - No latch inferred; every input combination drives a defined value.
- out does not depend on clk or rst_n; it is valid during reset.
- Data inputs affect only the output bits of the same index (bitwise selection). There is no carry or width conversion.
- X/Z on select with strobe_n=0:
  - Bits where a[i]==d[i] output that common value.
  - Other bits may be X in simulation.
- Registered path:
  - On each rising clk edge with rst_n=1, out_q takes the current value of out, including the strobe_n forcing.
  - Latency is one clock cycle from an input change to out_q.
- Reset:
  - rst_n=0 clears out_q to all zeros immediately, without waiting for a clock edge.
  - out_q holds zero for as long as rst_n=0.
  - The first capture happens on the first rising clk edge after rst_n returns to 1.
  - Release of reset coincident with a clock edge is treated as still in reset, so out_q stays 0 for that edge.
- Simultaneous changes:
  - If select and data change together, out settles to the new selected data within the same delta; no glitch requirement applies to out.
  - out_q samples only at clock edges and is glitch-free.
- There is no state machine, no handshake, no backpressure, and no storage other than the out_q register.
- WIDTH must be at least 1; all widths follow the parameter.

Test Plan:
- Idle: rst_n=0 then 1, a=0000, d=0000, select=0, strobe_n=0 -> out=0000; out_q=0000 during reset and after the first clock.
- Select toggle A:
  - a=1010, d=0101, select=0 -> out=1010.
  - Then select=1 -> out=0101.
  - out_q follows each value one clk edge later.
- Select toggle B:
  - a=1111, d=0000, select=0 -> out=1111.
  - select=1 -> out=0000.
- Select toggle C:
  - a=0011, d=1100, select=0 -> out=0011.
  - select=1 -> out=1100.
- Strobe: a=1111, d=1111, strobe_n=1 with select at 0 and at 1 -> out=0000; out_q=0000 after the next edge.
  - Then strobe_n=0 -> out=1111 immediately.
- Reset mid-operation:
  - With out_q=1010, assert rst_n=0 between clock edges -> out_q=0000 immediately, while out stays 1010.
  - Deassert rst_n -> out_q=1010 after the next rising edge.
